// File: rtl/en_sync_capture_pkg.sv
// Shared constants and types for the enable-synchronized capture block.
// Holds edge-mode selectors, drop counter width and the buffer fill encoding.
package en_sync_capture_pkg;

  localparam int EDGE_RISE  = 0;
  localparam int EDGE_ANY   = 1;
  localparam int DROP_CNT_W = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_ONE = DROP_CNT_W'(1);

  // Fill level of the 2-entry capture buffer
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    return (value == DROP_CNT_MAX) ? value : value + DROP_CNT_ONE;
  endfunction

endpackage

// File: rtl/en_edge_detect.sv
// Edge detector on the synchronized enable level. The detector stays disarmed
// for one cycle after reset so a level already high at release is not an edge.
module en_edge_detect
  import en_sync_capture_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic en_sync,
  output logic en_edge
);

  logic en_prev_reg;
  logic armed_reg;
  logic raw_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_prev_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      en_prev_reg <= en_sync;
      armed_reg   <= 1'b1;
    end
  end

  generate
    if (EDGE_MODE == EDGE_ANY) begin : g_any
      assign raw_edge = en_sync ^ en_prev_reg;
    end else begin : g_rise
      assign raw_edge = en_sync & ~en_prev_reg;
    end
  endgenerate

  assign en_edge = armed_reg & raw_edge;

endmodule

// File: rtl/en_sync_capture.sv
// Captures the source bus on each detected enable edge into a 2-entry buffer
// drained by valid/ready; captures into a full buffer are dropped and counted.
module en_sync_capture
  import en_sync_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_sync,
  input  logic [WIDTH-1:0]      i_bus,
  output logic                  o_pulse,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt,
  input  logic                  i_clr_ovf
);

  logic                  en_edge;
  logic [WIDTH-1:0]      mem_reg [2];
  buf_cnt_t              count_reg, count_next;
  logic                  wr_ptr_reg, wr_ptr_next;
  logic                  rd_ptr_reg, rd_ptr_next;
  logic                  pulse_reg;
  logic                  ovf_reg, ovf_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic                  pop;
  logic                  push;
  logic                  drop;

  en_edge_detect #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk     (i_clk),
    .rst     (i_rst),
    .en_sync (i_en_sync),
    .en_edge (en_edge)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg    <= CNT_EMPTY;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      pulse_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      pulse_reg    <= en_edge;
      ovf_reg      <= ovf_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage needs no reset: o_data is masked while the buffer is empty
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem_reg[wr_ptr_reg] <= i_bus;
    end
  end

  always_comb begin
    pop           = (count_reg != CNT_EMPTY) & i_ready;
    push          = en_edge & ((count_reg != CNT_FULL) | pop);
    drop          = en_edge & (count_reg == CNT_FULL) & ~pop;
    count_next    = count_reg;
    wr_ptr_next   = push ? ~wr_ptr_reg : wr_ptr_reg;
    rd_ptr_next   = pop ? ~rd_ptr_reg : rd_ptr_reg;
    ovf_next      = ovf_reg;
    drop_cnt_next = drop_cnt_reg;

    case ({push, pop})
      2'b10: begin
        case (count_reg)
          CNT_EMPTY: count_next = CNT_ONE;
          CNT_ONE:   count_next = CNT_FULL;
          default:   count_next = count_reg;
        endcase
      end
      2'b01: begin
        case (count_reg)
          CNT_FULL: count_next = CNT_ONE;
          CNT_ONE:  count_next = CNT_EMPTY;
          default:  count_next = count_reg;
        endcase
      end
      default: count_next = count_reg;
    endcase

    // A drop in the same cycle as a clear restarts the count at one
    if (drop) begin
      ovf_next      = 1'b1;
      drop_cnt_next = i_clr_ovf ? DROP_CNT_ONE : sat_inc(drop_cnt_reg);
    end else if (i_clr_ovf) begin
      ovf_next      = 1'b0;
      drop_cnt_next = '0;
    end
  end

  assign o_pulse    = pulse_reg;
  assign o_valid    = (count_reg != CNT_EMPTY);
  assign o_data     = (count_reg == CNT_EMPTY) ? '0 : mem_reg[rd_ptr_reg];
  assign o_overflow = ovf_reg;
  assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_en_sync_capture.sv
// Bench for en_sync_capture: a rising-edge and an any-edge instance share the
// stimulus and are compared every cycle against a queue-based reference model.
module tb_en_sync_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] bus;
  logic       ready;
  logic       clr;

  logic       pulse_o    [2];
  logic [7:0] data_o     [2];
  logic       valid_o    [2];
  logic       ovf_o      [2];
  logic [7:0] drop_cnt_o [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  en_sync_capture #(.WIDTH(8), .EDGE_MODE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en_sync(en), .i_bus(bus),
    .o_pulse(pulse_o[0]), .o_data(data_o[0]), .o_valid(valid_o[0]),
    .i_ready(ready), .o_overflow(ovf_o[0]), .o_drop_cnt(drop_cnt_o[0]),
    .i_clr_ovf(clr)
  );

  en_sync_capture #(.WIDTH(8), .EDGE_MODE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en_sync(en), .i_bus(bus),
    .o_pulse(pulse_o[1]), .o_data(data_o[1]), .o_valid(valid_o[1]),
    .i_ready(ready), .o_overflow(ovf_o[1]), .o_drop_cnt(drop_cnt_o[1]),
    .i_clr_ovf(clr)
  );

  // Reference model: a word queue plus sticky flag/counter per instance
  logic [7:0] mq [2][$];
  bit         m_armed [2];
  bit         m_prev  [2];
  bit         m_pulse [2];
  bit         m_ovf   [2];
  int         m_cnt   [2];

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit e;
      bit popv;
      bit was_full;
      bit dropped;
      if (rst) begin
        mq[m].delete();
        m_armed[m] = 1'b0;
        m_prev[m]  = 1'b0;
        m_pulse[m] = 1'b0;
        m_ovf[m]   = 1'b0;
        m_cnt[m]   = 0;
      end else begin
        e        = m_armed[m] && ((m == 1) ? (en != m_prev[m]) : (en && !m_prev[m]));
        popv     = (mq[m].size() > 0) && ready;
        was_full = (mq[m].size() == 2);
        if (popv) begin
          if (m == 0) $display("pop dut0 data=%02h t=%0t", mq[m][0], $time);
          void'(mq[m].pop_front());
        end
        dropped = e && was_full && !popv;
        if (e && !dropped) mq[m].push_back(bus);
        if (dropped) begin
          m_ovf[m] = 1'b1;
          m_cnt[m] = clr ? 1 : ((m_cnt[m] < 255) ? m_cnt[m] + 1 : 255);
        end else if (clr) begin
          m_ovf[m] = 1'b0;
          m_cnt[m] = 0;
        end
        m_pulse[m] = e;
        m_prev[m]  = en;
        m_armed[m] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("dut%0d pulse", m), 32'(pulse_o[m]), 32'(m_pulse[m]));
        check($sformatf("dut%0d valid", m), 32'(valid_o[m]), 32'(mq[m].size() > 0));
        check($sformatf("dut%0d data", m), 32'(data_o[m]),
              (mq[m].size() > 0) ? 32'(mq[m][0]) : 32'd0);
        check($sformatf("dut%0d overflow", m), 32'(ovf_o[m]), 32'(m_ovf[m]));
        check($sformatf("dut%0d drop_cnt", m), 32'(drop_cnt_o[m]), 32'(m_cnt[m]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ready = 1'b0; clr = 1'b0; bus = 8'h00;
    step(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset valid", 32'(valid_o[0]), 32'd0);
    check("reset data", 32'(data_o[0]), 32'd0);
    check("reset ovf", 32'(ovf_o[1]), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt_o[1]), 32'd0);

    // Release with enable already high: no capture in either mode
    rst = 1'b0;
    step(10);
    @(negedge clk);
    check("hold-high valid0", 32'(valid_o[0]), 32'd0);
    check("hold-high valid1", 32'(valid_o[1]), 32'd0);

    // Single rising edge with ready high
    en = 1'b0; step(2);
    bus = 8'hA5; ready = 1'b1; en = 1'b1;
    step(1); @(negedge clk);
    check("edge pulse N+1", 32'(pulse_o[0]), 32'd1);
    check("edge valid N+1", 32'(valid_o[0]), 32'd1);
    check("edge data N+1", 32'(data_o[0]), 32'hA5);
    step(1); @(negedge clk);
    check("edge pulse N+2", 32'(pulse_o[0]), 32'd0);
    check("edge valid N+2", 32'(valid_o[0]), 32'd0);

    // Three rising edges into a stalled buffer
    ready = 1'b0; en = 1'b0; step(1);
    bus = 8'h11; en = 1'b1; step(1);
    en = 1'b0; step(1);
    bus = 8'h22; en = 1'b1; step(1);
    en = 1'b0; step(1);
    bus = 8'h33; en = 1'b1; step(1);
    en = 1'b0; @(negedge clk);
    check("overflow set", 32'(ovf_o[0]), 32'd1);
    check("drop_cnt one", 32'(drop_cnt_o[0]), 32'd1);
    check("head 0x11", 32'(data_o[0]), 32'h11);
    step(1);

    // Edge into a full buffer while popping: accepted
    bus = 8'h44; en = 1'b1; ready = 1'b1;
    step(1); @(negedge clk);
    check("full+pop head 0x22", 32'(data_o[0]), 32'h22);
    check("full+pop no drop", 32'(drop_cnt_o[0]), 32'd1);
    step(1); @(negedge clk);
    check("queued 0x44", 32'(data_o[0]), 32'h44);
    step(1); @(negedge clk);
    check("drained valid", 32'(valid_o[0]), 32'd0);
    ready = 1'b0;

    clr = 1'b1; step(1); clr = 1'b0;
    @(negedge clk);
    check("clear ovf", 32'(ovf_o[0]), 32'd0);
    check("clear drop_cnt", 32'(drop_cnt_o[0]), 32'd0);

    // 300 toggles with ready low: any-edge saturates, rising-edge drops 148
    for (int i = 0; i < 300; i++) begin
      en = ~en;
      step(1);
    end
    @(negedge clk);
    check("any-edge saturate", 32'(drop_cnt_o[1]), 32'd255);
    check("rise-edge drops", 32'(drop_cnt_o[0]), 32'd148);

    // Clear and drop together (any-edge only sees this falling edge)
    en = ~en; clr = 1'b1; step(1); clr = 1'b0;
    @(negedge clk);
    check("clr+drop ovf1", 32'(ovf_o[1]), 32'd1);
    check("clr+drop cnt1", 32'(drop_cnt_o[1]), 32'd1);
    check("clr only ovf0", 32'(ovf_o[0]), 32'd0);
    check("clr only cnt0", 32'(drop_cnt_o[0]), 32'd0);
    check("pre-reset full", 32'(valid_o[0]), 32'd1);

    // Reset while full, with an edge in the reset cycle
    rst = 1'b1; en = 1'b1; step(1); rst = 1'b0;
    @(negedge clk);
    check("flush valid", 32'(valid_o[0]), 32'd0);
    check("flush data", 32'(data_o[0]), 32'd0);
    check("flush ovf", 32'(ovf_o[1]), 32'd0);
    step(1);
    en = 1'b0; step(1);
    bus = 8'h5A; en = 1'b1; step(1);
    @(negedge clk);
    check("post-reset capture", 32'(data_o[0]), 32'h5A);
    check("post-reset valid", 32'(valid_o[0]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) en = ~en;
      bus   = 8'($urandom);
      ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; clr = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
